// File: rtl/round_controller_pkg.sv
// Shared types and constants for the round_controller bidding game.
package round_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    COMPARE,
    ANNOUNCE,
    DONE
  } state_t;

  localparam int BID_W   = 7;
  localparam int SCORE_W = 4;

  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;
  localparam int D = 3;

endpackage

// File: rtl/round_controller_max4.sv
// max4_select: one-hot pick of the largest of four bids, ties to the highest index.
module max4_select
  import round_controller_pkg::*;
(
  input  logic [BID_W-1:0] bids [4],
  output logic [3:0]       sel
);

  logic [BID_W-1:0] best;
  logic [1:0]       idx;

  // Scan downward; a lower index only wins if strictly larger.
  always_comb begin
    best = bids[D];
    idx  = 2'(D);
    for (int i = D - 1; i >= 0; i--) begin
      if (bids[i] > best) begin
        best = bids[i];
        idx  = 2'(i);
      end
    end
    sel      = '0;
    sel[idx] = 1'b1;
  end

endmodule

// File: rtl/round_controller.sv
// Four-player sealed-bid round controller; optional collect timeout under ROUND_TIMEOUT_EN.
module round_controller
  import round_controller_pkg::*;
#(
  parameter int NUM_ROUNDS     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BID_W-1:0]   bid_a,
  input  logic [BID_W-1:0]   bid_b,
  input  logic [BID_W-1:0]   bid_c,
  input  logic [BID_W-1:0]   bid_d,
  input  logic [3:0]         bid_valid,
  output logic [3:0]         bid_ack,
  output logic [3:0]         winner,
  output logic               winner_valid,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SCORE_W-1:0] score_c,
  output logic [SCORE_W-1:0] score_d,
  output logic [3:0]         round_num,
  output logic               busy,
  output logic               game_over
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15 ||
      TIMEOUT_CYCLES < 1) begin : gBadCfg
    $error("round_controller: bad parameters");
  end

  state_t state;

  logic [BID_W-1:0]   bidIn  [4];
  logic [BID_W-1:0]   bidReg [4];
  logic [SCORE_W-1:0] score  [4];
  logic [3:0]         captured;
  logic [3:0]         ackNow;
  logic [3:0]         sel;
  logic               haveAll;
  logic               expired;

  assign bidIn[A] = bid_a;
  assign bidIn[B] = bid_b;
  assign bidIn[C] = bid_c;
  assign bidIn[D] = bid_d;

  assign ackNow  = (state == COLLECT) ?
                   (bid_valid & ~captured) : 4'b0;
  assign haveAll = &(captured | ackNow);

  assign bid_ack   = ackNow;
  assign busy      = state inside {COLLECT, COMPARE, ANNOUNCE};
  assign game_over = (state == DONE);

  assign score_a = score[A];
  assign score_b = score[B];
  assign score_c = score[C];
  assign score_d = score[D];

  max4_select uSel (
    .bids (bidReg),
    .sel  (sel)
  );

`ifdef ROUND_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast =
    CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt;

  // Restarts every time COLLECT is (re)entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (state != COLLECT)
      cnt <= '0;
    else if (!expired)
      cnt <= cnt + 1'b1;
  end

  assign expired = (state == COLLECT) &&
                   (cnt == CntLast) && !haveAll;
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      captured     <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      round_num    <= '0;
      for (int i = 0; i < 4; i++) begin
        bidReg[i] <= '0;
        score[i]  <= '0;
      end
    end else begin
      winner_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            captured  <= '0;
            winner    <= '0;
            round_num <= '0;
            for (int i = 0; i < 4; i++)
              score[i] <= '0;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          for (int i = 0; i < 4; i++) begin
            if (ackNow[i])
              bidReg[i] <= bidIn[i];
            else if (expired && !captured[i])
              bidReg[i] <= '0;
          end
          captured <= captured | ackNow;
          if (haveAll || expired)
            state <= COMPARE;
        end
        COMPARE: begin
          winner       <= sel;
          winner_valid <= 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (sel[i] && score[i] != ScoreMax)
              score[i] <= score[i] + 1'b1;
          end
          round_num <= round_num + 1'b1;
          captured  <= '0;
          state     <= ANNOUNCE;
        end
        ANNOUNCE: begin
          state <= (round_num < LastRound) ? COLLECT : DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter NUM_ROUNDS, default 8: rounds per game, range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: collect-phase timeout in clocks, used only under REQ-028.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begin a game; level-sampled.
REQ-006 bid_a, bid_b, bid_c, bid_d  in  7 each  player bid values.
REQ-007 bid_valid  in  4  per-player bid strobe; bit0=a .. bit3=d.
REQ-008 bid_ack  out  4  one-cycle pulse per player when that player's bid is captured.
REQ-009 winner  out  4  one-hot round winner, same bit order as bid_valid.
REQ-010 winner_valid  out  1  one-cycle pulse qualifying winner.
REQ-011 score_a, score_b, score_c, score_d  out  4 each  rounds won per player.
REQ-012 round_num  out  4  rounds completed in the current game.
REQ-013 busy  out  1  high in every state except IDLE and DONE.
REQ-014 game_over  out  1  high while in DONE.

Function
REQ-015 FSM states: IDLE, COLLECT, COMPARE, ANNOUNCE, DONE.
- IDLE->COLLECT when start=1.
- COLLECT->COMPARE on the cycle after all four bids are captured.
- COMPARE->ANNOUNCE unconditionally.
- ANNOUNCE->COLLECT if round_num < NUM_ROUNDS after increment; otherwise ANNOUNCE->DONE.
- DONE->COLLECT when start=1.
REQ-016 In COLLECT, a player's bid is captured into a 7-bit register, its captured flag is set and its bid_ack bit is pulsed, all in the cycle its bid_valid bit is 1 and its flag is clear.
REQ-017 bid_valid for a player whose flag is already set is ignored: no ack, no register change.
REQ-018 Several players are captured in the same cycle if their bid_valid bits are high together.
REQ-019 Comparison is unsigned over the captured registers; the largest value wins.
REQ-020 Ties for the maximum resolve to the highest-index tied player (d > c > b > a).
REQ-021 winner is registered in COMPARE and held stable until the next COMPARE.
REQ-022 winner_valid pulses for exactly one cycle, in ANNOUNCE.
REQ-023 Latency: with the last bid captured at cycle N, winner_valid is high at cycle N+2.
REQ-024 In ANNOUNCE, the winner's score and round_num each increment by 1, and all captured flags clear.
- Scores saturate at 15.
- The next round accepts bids from the following cycle.
REQ-025 start in COLLECT, COMPARE or ANNOUNCE is ignored.
- start in IDLE or DONE clears all scores, round_num, winner and flags before entering COLLECT.

Reset
REQ-026 rst forces IDLE asynchronously.
- bid_ack, winner, winner_valid, all scores, round_num, busy and game_over are 0.
- All bid registers, captured flags and the timeout counter are 0.
REQ-027 Reset mid-round discards all captured bids; there is no partial announce.

Configuration
REQ-028 With macro ROUND_TIMEOUT_EN defined, a counter runs in COLLECT, restarting at each round entry.
- When TIMEOUT_CYCLES clocks elapse with bids still missing, each missing player's bid is forced to 0 and the FSM goes to COMPARE.
- A forced bid gets no bid_ack.
- Without the macro, COLLECT waits indefinitely and no counter is instantiated.

Structure
REQ-029 A shared package holds:
- the FSM state typedef;
- BID_W=7, SCORE_W=4 and player index constants A=0..D=3.
REQ-030 One combinational sub-module, max4_select, takes four BID_W values and returns the one-hot winner per REQ-019/REQ-020.

Verification
REQ-031 Bids a=10, b=20, c=30, d=40 all in one cycle -> bid_ack=1111 that cycle; winner=1000 and score_d=1 two cycles later.
REQ-032 Bids a=50, b=50, c=5, d=5 -> winner=0010; all four equal (99) -> winner=1000.
REQ-033 Player b asserts bid_valid=1 for 3 consecutive cycles before the others bid -> bid_ack[1] pulses exactly once and the first value is kept.
REQ-034 NUM_ROUNDS=2, player a wins both rounds -> game_over=1, score_a=2, round_num=2; start then clears scores and enters COLLECT.
REQ-035 rst asserted in COLLECT with 3 bids captured -> all outputs 0 immediately and no winner_valid follows.
REQ-036 With ROUND_TIMEOUT_EN and TIMEOUT_CYCLES=4, only a=7 is bid -> winner=0001 after the timeout; no bid_ack for b, c or d.
